pkt_hdr_arbiter: RTL and testbench
==================================

Name: pkt_hdr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one 512-bit AXI-stream egress, feeding the shared header classifier/match stage, between NUM_PORTS ingress streams inside box_250mhz.
- Holds the grant for a whole packet, from first beat to tlast.
- Decodes the first beat of each granted packet into a registered header summary: L3/L4 class, ports, source index.

Parameters:
NUM_PORTS, 4, number of ingress requesters (2..8)
DATA_W, 512, tdata width; fixed, header decode relies on it
SRC_W, $clog2(NUM_PORTS), width of source index

Ports:
axis_aclk  in  1  clock
mod_rstn  in  1  asynchronous active-low reset
s_axis_tvalid  in  NUM_PORTS  per-port valid
s_axis_tdata  in  NUM_PORTS*DATA_W  per-port data; port i at slice i
s_axis_tkeep  in  NUM_PORTS*DATA_W/8  per-port keep
s_axis_tlast  in  NUM_PORTS  per-port last
s_axis_tready  out  NUM_PORTS  per-port ready
m_axis_tvalid  out  1  egress valid
m_axis_tdata  out  DATA_W  egress data
m_axis_tkeep  out  DATA_W/8  egress keep
m_axis_tlast  out  1  egress last
m_axis_tuser_src  out  SRC_W  granted port index
m_axis_tready  in  1  egress ready
hdr_valid  out  1  one-cycle pulse: header summary valid
hdr_src  out  SRC_W  port the header came from
hdr_l3  out  2  0 other, 1 IPv4, 2 IPv6
hdr_l4  out  2  0 other, 1 TCP, 2 UDP
hdr_ports  out  32  {src_port,dst_port}; 0 when hdr_l4==0

Behaviour:
- Reset: IDLE state, rr pointer 0, grant 0, all tready 0, m_axis_tvalid 0, hdr_valid 0, hdr_* 0.
- Byte order: byte 0 of the frame is tdata[DATA_W-1 -: 8]. The beat is cast directly onto the shared eth_ipv4_pkt_t / eth_ipv6_pkt_t structs.
- FSM IDLE:
  - If no s_axis_tvalid is set, stay in IDLE.
  - Otherwise pick the first valid port searching from the rr pointer upward, with wrap.
  - Register it as the grant and go to PKT.
  - All tready stay 0 in IDLE. Arbitration latency is 1 cycle.
- FSM PKT: combinational pass-through of the granted port only.
  - m_axis_tvalid = s_axis_tvalid[g]; s_axis_tready[g] = m_axis_tready.
  - Non-granted tready = 0. m_axis_tuser_src = g.
  - On a tlast handshake: rr pointer = g+1 (wraps to 0 after NUM_PORTS-1), return to IDLE. This gives a one-cycle bubble between packets.
- Grant is locked for the whole packet. The granted port dropping tvalid mid-packet does not release the grant. m_axis_tready low stalls with no data loss.
- First-beat flag: set on entry to PKT, cleared on the first handshake.
- Header decode, on the first-beat handshake, registered; hdr_valid pulses 1 cycle after that handshake:
  - eth_type 0x0800, version 4, ihl 5 → l3=IPv4.
    - protocol 6/17 with frag_offset 0 and MF flag 0 → l4 TCP/UDP, ports from port_hdr_t.
    - Otherwise l4=0.
  - eth_type 0x86DD, version 6 → l3=IPv6.
    - next_header 6/17 → l4 TCP/UDP, ports taken.
    - Otherwise l4=0.
  - Anything else → l3=0, l4=0, ports 0.
  - hdr_src = g. hdr_* hold their values between pulses.
- Single-beat packet (first beat carries tlast): header pulse and release both occur.
- tkeep is not checked by the decoder.
- Reset asserted mid-packet: immediate return to reset values. The partial packet is truncated downstream; no recovery is attempted.

Optional Feature:
- Macro: PKT_HDR_ARB_STATS_EN.
- Defined:
  - Adds output pkt_cnt[NUM_PORTS*32]: per-port counts of completed packets (tlast handshakes), wrapping at 2^32.
  - Adds output hdr_other_cnt[32]: count of headers decoded with l3==0.
  - All counters reset to 0.
- Undefined: these ports and this logic are absent.

Decomposition:
- Shared packet package: existing header structs plus new constants HDR_L3_OTHER/IPV4/IPV6 and HDR_L4_OTHER/TCP/UDP, and the hdr_summary_t struct {src, l3, l4, ports}.
- Sub-module rr_arbiter: combinational round-robin pick from request vector and pointer, returning a one-hot grant and an index. It is reusable elsewhere.
- Header decode is a function in the package.

Test Plan:
- Ports 0–3 all valid, each sending 3-beat packets, tready=1 → egress order 0,1,2,3,0; one idle cycle between packets; tuser_src matches.
- Port 2 IPv4/UDP, src_port 0x1234, dst_port 0x5678 → hdr_valid 1 cycle after the first handshake; l3=1, l4=2, hdr_ports=0x12345678, hdr_src=2.
- IPv6/TCP single-beat packet on port 1 → l3=2, l4=1; grant released that cycle; rr pointer=2.
- IPv4 with frag_offset=0x10, and separately an ARP frame with eth_type 0x0806 → IPv4 case: l3=1, l4=0, ports=0; ARP case: l3=0, l4=0, ports=0.
- m_axis_tready toggles, and port 0 drops tvalid mid-packet while port 3 requests → no beat lost or duplicated; port 3 is not granted until port 0's tlast.
- Reset pulsed during beat 2 of a packet → all outputs 0; first grant after reset goes to port 0 when ports 0 and 3 both request.

Source files
------------

// File: rtl/pkt_hdr_arbiter_pkg.sv
// Shared packet types: Ethernet/IPv4/IPv6 header overlays for a 512-bit first beat,
// header summary constants, and the first-beat header decode function.
package pkt_hdr_arbiter_pkg;

    localparam int PKT_DATA_W = 512;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;
    localparam logic [7:0]  IP_PROTO_TCP  = 8'd6;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

    localparam logic [1:0] HDR_L3_OTHER = 2'd0;
    localparam logic [1:0] HDR_L3_IPV4  = 2'd1;
    localparam logic [1:0] HDR_L3_IPV6  = 2'd2;
    localparam logic [1:0] HDR_L4_OTHER = 2'd0;
    localparam logic [1:0] HDR_L4_TCP   = 2'd1;
    localparam logic [1:0] HDR_L4_UDP   = 2'd2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_PKT  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] eth_type;
    } eth_hdr_t;

    // flags = {reserved, DF, MF}
    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [7:0]  tos;
        logic [15:0] total_len;
        logic [15:0] id;
        logic [2:0]  flags;
        logic [12:0] frag_offset;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] checksum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } ipv4_hdr_t;

    typedef struct packed {
        logic [3:0]   version;
        logic [7:0]   traffic_class;
        logic [19:0]  flow_label;
        logic [15:0]  payload_len;
        logic [7:0]   next_header;
        logic [7:0]   hop_limit;
        logic [127:0] src_ip;
        logic [127:0] dst_ip;
    } ipv6_hdr_t;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
    } port_hdr_t;

    typedef struct packed {
        eth_hdr_t     eth;
        ipv4_hdr_t    ip;
        port_hdr_t    l4;
        logic [207:0] pad;
    } eth_ipv4_pkt_t;

    typedef struct packed {
        eth_hdr_t    eth;
        ipv6_hdr_t   ip;
        port_hdr_t   l4;
        logic [47:0] pad;
    } eth_ipv6_pkt_t;

    typedef struct packed {
        logic [2:0]  src;
        logic [1:0]  l3;
        logic [1:0]  l4;
        logic [31:0] ports;
    } hdr_summary_t;

    // Byte 0 of the frame sits in the top byte, so the structs overlay the beat directly.
    function automatic hdr_summary_t decode_hdr(input logic [PKT_DATA_W-1:0] beat);
        eth_ipv4_pkt_t v4;
        eth_ipv6_pkt_t v6;
        hdr_summary_t  s;
        v4 = beat;
        v6 = beat;
        s  = '0;
        if (v4.eth.eth_type == ETH_TYPE_IPV4 && v4.ip.version == 4'd4 && v4.ip.ihl == 4'd5) begin
            s.l3 = HDR_L3_IPV4;
            if (v4.ip.frag_offset == '0 && !v4.ip.flags[0]) begin
                if (v4.ip.protocol == IP_PROTO_TCP)      s.l4 = HDR_L4_TCP;
                else if (v4.ip.protocol == IP_PROTO_UDP) s.l4 = HDR_L4_UDP;
            end
            if (s.l4 != HDR_L4_OTHER) s.ports = v4.l4;
        end else if (v6.eth.eth_type == ETH_TYPE_IPV6 && v6.ip.version == 4'd6) begin
            s.l3 = HDR_L3_IPV6;
            if (v6.ip.next_header == IP_PROTO_TCP)      s.l4 = HDR_L4_TCP;
            else if (v6.ip.next_header == IP_PROTO_UDP) s.l4 = HDR_L4_UDP;
            if (s.l4 != HDR_L4_OTHER) s.ports = v6.l4;
        end
        return s;
    endfunction

endpackage

// File: rtl/pkt_hdr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping,
// returned both one-hot and as an index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    always_comb begin
        int j;
        j         = 0;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!gnt_valid && req[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(j);
                gnt[j]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_hdr_arbiter.sv
// Packet-level round-robin AXI-stream arbiter with first-beat header summary.
// Optional statistics counters are enabled with PKT_HDR_ARB_STATS_EN.
module pkt_hdr_arbiter
    import pkt_hdr_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = PKT_DATA_W,
    parameter int SRC_W     = $clog2(NUM_PORTS)
) (
    input  logic                          axis_aclk,
    input  logic                          mod_rstn,
    input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
    input  logic [NUM_PORTS*DATA_W-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]          s_axis_tlast,
    output logic [NUM_PORTS-1:0]          s_axis_tready,
    output logic                          m_axis_tvalid,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic [DATA_W/8-1:0]           m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic [SRC_W-1:0]              m_axis_tuser_src,
    input  logic                          m_axis_tready,
    output logic                          hdr_valid,
    output logic [SRC_W-1:0]              hdr_src,
    output logic [1:0]                    hdr_l3,
    output logic [1:0]                    hdr_l4,
    output logic [31:0]                   hdr_ports
`ifdef PKT_HDR_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]       pkt_cnt,
    output logic [31:0]                   hdr_other_cnt
`endif
);

    // state    | meaning
    // ARB_IDLE | no grant held; arbitrate among valid ports
    // ARB_PKT  | grant locked to grant_q until its tlast handshake

    localparam int KEEP_W = DATA_W / 8;

    arb_state_t           state_q, state_d;
    logic [SRC_W-1:0]     rr_ptr_q, grant_q, pick_idx;
    logic [NUM_PORTS-1:0] grant_oh_q, pick_oh;
    logic                 pick_valid, first_q, beat_hs, last_hs;
    logic                 hdr_valid_q;
    hdr_summary_t         hdr_q, hdr_dec;

    rr_arbiter #(.N(NUM_PORTS), .IDX_W(SRC_W)) u_rr_arbiter (
        .req       (s_axis_tvalid),
        .ptr       (rr_ptr_q),
        .gnt       (pick_oh),
        .gnt_idx   (pick_idx),
        .gnt_valid (pick_valid)
    );

    always_comb begin
        state_d       = state_q;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        beat_hs       = 1'b0;
        last_hs       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) state_d = ARB_PKT;
            end
            ARB_PKT: begin
                m_axis_tvalid = s_axis_tvalid[grant_q];
                m_axis_tdata  = s_axis_tdata[grant_q*DATA_W +: DATA_W];
                m_axis_tkeep  = s_axis_tkeep[grant_q*KEEP_W +: KEEP_W];
                m_axis_tlast  = s_axis_tlast[grant_q];
                s_axis_tready = grant_oh_q & {NUM_PORTS{m_axis_tready}};
                beat_hs       = s_axis_tvalid[grant_q] & m_axis_tready;
                last_hs       = beat_hs & s_axis_tlast[grant_q];
                if (last_hs) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        hdr_dec     = decode_hdr(m_axis_tdata);
        hdr_dec.src = 3'(grant_q);
    end

    always_ff @(posedge axis_aclk or negedge mod_rstn) begin
        if (!mod_rstn) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            grant_oh_q  <= '0;
            first_q     <= 1'b0;
            hdr_valid_q <= 1'b0;
            hdr_q       <= '0;
        end else begin
            state_q     <= state_d;
            hdr_valid_q <= 1'b0;
            if (state_q == ARB_IDLE && pick_valid) begin
                grant_q    <= pick_idx;
                grant_oh_q <= pick_oh;
                first_q    <= 1'b1;
            end
            if (beat_hs) first_q <= 1'b0;
            if (beat_hs && first_q) begin
                hdr_valid_q <= 1'b1;
                hdr_q       <= hdr_dec;
            end
            if (last_hs)
                rr_ptr_q <= (grant_q == SRC_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    assign m_axis_tuser_src = grant_q;
    assign hdr_valid        = hdr_valid_q;
    assign hdr_src          = hdr_q.src[SRC_W-1:0];
    assign hdr_l3           = hdr_q.l3;
    assign hdr_l4           = hdr_q.l4;
    assign hdr_ports        = hdr_q.ports;

`ifdef PKT_HDR_ARB_STATS_EN
    always_ff @(posedge axis_aclk or negedge mod_rstn) begin
        if (!mod_rstn) begin
            pkt_cnt       <= '0;
            hdr_other_cnt <= '0;
        end else begin
            if (last_hs)
                pkt_cnt[grant_q*32 +: 32] <= pkt_cnt[grant_q*32 +: 32] + 32'd1;
            if (beat_hs && first_q && hdr_dec.l3 == HDR_L3_OTHER)
                hdr_other_cnt <= hdr_other_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_hdr_arbiter.sv
// Self-checking bench for pkt_hdr_arbiter: directed scenarios plus randomized packets,
// checked against a packet-level reference model with a byte-oriented header parser.
module tb_pkt_hdr_arbiter;

    localparam int NP = 4;
    localparam int DW = 512;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP-1:0]     s_tvalid = '0;
    logic [NP*DW-1:0]  s_tdata = '0;
    logic [NP*KW-1:0]  s_tkeep = '0;
    logic [NP-1:0]     s_tlast = '0;
    logic [NP-1:0]     s_tready;
    logic              m_tvalid;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic [1:0]        m_tuser_src;
    logic              m_rdy = 1'b0;
    logic              hdr_valid;
    logic [1:0]        hdr_src, hdr_l3, hdr_l4;
    logic [31:0]       hdr_ports;

    always #5 clk = ~clk;

    pkt_hdr_arbiter #(.NUM_PORTS(NP)) dut (
        .axis_aclk        (clk),
        .mod_rstn         (rst_n),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tdata     (s_tdata),
        .s_axis_tkeep     (s_tkeep),
        .s_axis_tlast     (s_tlast),
        .s_axis_tready    (s_tready),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tdata     (m_tdata),
        .m_axis_tkeep     (m_tkeep),
        .m_axis_tlast     (m_tlast),
        .m_axis_tuser_src (m_tuser_src),
        .m_axis_tready    (m_rdy),
        .hdr_valid        (hdr_valid),
        .hdr_src          (hdr_src),
        .hdr_l3           (hdr_l3),
        .hdr_l4           (hdr_l4),
        .hdr_ports        (hdr_ports)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    beat_t q_src [NP][$];
    beat_t q_exp [NP][$];
    int    dut_log[$];

    // Reference model state: packet owner, rr pointer, pending header expectation
    bit          m_busy = 0, m_first = 0, pend = 0;
    int          m_owner = 0, m_ptr = 0;
    logic [1:0]  e_l3 = 0, e_l4 = 0, e_src = 0;
    logic [31:0] e_ports = 0;
    bit          rand_valid[NP];
    bit          rand_ready = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand512();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [7:0] bt(input logic [DW-1:0] d, input int k);
        return d[DW-1-8*k -: 8];
    endfunction

    // kind: 0 IPv4, 1 IPv6, 2 ARP, 3 arbitrary ethertype
    function automatic logic [DW-1:0] mk_hdr(input int kind, input int proto,
                                             input logic [15:0] sp, input logic [15:0] dp,
                                             input logic [12:0] frag, input bit mf, input bit bad_ver);
        logic [7:0]    b [64];
        logic [DW-1:0] d;
        for (int k = 0; k < 64; k++) b[k] = 8'($urandom);
        case (kind)
            0: begin
                b[12] = 8'h08; b[13] = 8'h00;
                b[14] = bad_ver ? 8'h46 : 8'h45;
                b[20] = {2'b00, mf, frag[12:8]};
                b[21] = frag[7:0];
                b[23] = 8'(proto);
                b[34] = sp[15:8]; b[35] = sp[7:0]; b[36] = dp[15:8]; b[37] = dp[7:0];
            end
            1: begin
                b[12] = 8'h86; b[13] = 8'hDD;
                b[14] = {(bad_ver ? 4'h4 : 4'h6), b[14][3:0]};
                b[20] = 8'(proto);
                b[54] = sp[15:8]; b[55] = sp[7:0]; b[56] = dp[15:8]; b[57] = dp[7:0];
            end
            2: begin
                b[12] = 8'h08; b[13] = 8'h06;
            end
            default: ;
        endcase
        for (int k = 0; k < 64; k++) d[DW-1-8*k -: 8] = b[k];
        return d;
    endfunction

    // Returns {l3, l4, ports} parsed byte-wise from the frame
    function automatic logic [35:0] ref_decode(input logic [DW-1:0] d);
        logic [15:0] et;
        logic [7:0]  b14, b20, b21, pr;
        logic [1:0]  l3, l4;
        logic [31:0] pt;
        et  = {bt(d, 12), bt(d, 13)};
        b14 = bt(d, 14);
        b20 = bt(d, 20);
        b21 = bt(d, 21);
        l3 = 0; l4 = 0; pt = 0;
        if (et == 16'h0800 && b14 == 8'h45) begin
            l3 = 1;
            pr = bt(d, 23);
            if (b20[5] == 1'b0 && b20[4:0] == 5'd0 && b21 == 8'd0 && (pr == 8'd6 || pr == 8'd17)) begin
                l4 = (pr == 8'd6) ? 2'd1 : 2'd2;
                pt = {bt(d, 34), bt(d, 35), bt(d, 36), bt(d, 37)};
            end
        end else if (et == 16'h86DD && b14[7:4] == 4'h6) begin
            l3 = 2;
            pr = b20;
            if (pr == 8'd6 || pr == 8'd17) begin
                l4 = (pr == 8'd6) ? 2'd1 : 2'd2;
                pt = {bt(d, 54), bt(d, 55), bt(d, 56), bt(d, 57)};
            end
        end
        return {l3, l4, pt};
    endfunction

    task automatic queue_pkt(input int p, input logic [DW-1:0] first, input int nbeats);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.d = (i == 0) ? first : rand512();
            b.k = {$urandom, $urandom};
            b.l = (i == nbeats - 1);
            q_src[p].push_back(b);
            q_exp[p].push_back(b);
        end
    endtask

    task automatic cycle();
        logic [NP-1:0] et;
        beat_t         e;
        logic [35:0]   dec;
        bit            found;
        @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            if (q_src[i].size() > 0 && (!rand_valid[i] || ($urandom % 3) != 0)) begin
                s_tvalid[i]           = 1'b1;
                s_tdata[i*DW +: DW]   = q_src[i][0].d;
                s_tkeep[i*KW +: KW]   = q_src[i][0].k;
                s_tlast[i]            = q_src[i][0].l;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
        m_rdy = rand_ready ? 1'($urandom % 2) : 1'b1;
        #1;
        if (m_busy) begin
            et = m_rdy ? (4'b0001 << m_owner) : 4'b0000;
            chk("tuser_src", DW'(m_tuser_src), DW'(m_owner));
            chk("tready", DW'(s_tready), DW'(et));
            chk("m_tvalid", DW'(m_tvalid), DW'(s_tvalid[m_owner]));
            if (s_tvalid[m_owner] && m_rdy) begin
                if (q_exp[m_owner].size() == 0) begin
                    chk("beat_unexpected", DW'(1), DW'(0));
                end else begin
                    e = q_exp[m_owner].pop_front();
                    chk("tdata", m_tdata, e.d);
                    chk("tkeep", DW'(m_tkeep), DW'(e.k));
                    chk("tlast", DW'(m_tlast), DW'(e.l));
                    if (m_first) begin
                        dec = ref_decode(e.d);
                        {e_l3, e_l4, e_ports} = dec;
                        e_src   = 2'(m_owner);
                        pend    = 1;
                        m_first = 0;
                        dut_log.push_back(int'(m_tuser_src));
                    end
                    if (e.l) begin
                        m_busy = 0;
                        m_ptr  = (m_owner + 1) % NP;
                    end
                end
            end
        end else begin
            chk("idle_tready", DW'(s_tready), DW'(0));
            chk("idle_tvalid", DW'(m_tvalid), DW'(0));
            found = 0;
            for (int k = 0; k < NP; k++) begin
                if (!found && s_tvalid[(m_ptr + k) % NP]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % NP;
                    m_busy  = 1;
                    m_first = 1;
                end
            end
        end
        for (int i = 0; i < NP; i++)
            if (s_tvalid[i] && s_tready[i] && q_src[i].size() > 0) void'(q_src[i].pop_front());
        @(posedge clk);
        #1;
        chk("hdr_valid", DW'(hdr_valid), DW'(pend));
        pend = 0;
        chk("hdr_l3", DW'(hdr_l3), DW'(e_l3));
        chk("hdr_l4", DW'(hdr_l4), DW'(e_l4));
        chk("hdr_ports", DW'(hdr_ports), DW'(e_ports));
        chk("hdr_src", DW'(hdr_src), DW'(e_src));
    endtask

    function automatic bit pending();
        bit p;
        p = m_busy;
        for (int i = 0; i < NP; i++) if (q_exp[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic run(input int max);
        int n;
        n = 0;
        while (pending() && n < max) begin
            cycle();
            n++;
        end
        chk("drain_within_budget", DW'(n < max), DW'(1));
        cycle();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tready"}, DW'(s_tready), DW'(0));
        chk({tag, "_tvalid"}, DW'(m_tvalid), DW'(0));
        chk({tag, "_tdata"}, m_tdata, DW'(0));
        chk({tag, "_tlast"}, DW'(m_tlast), DW'(0));
        chk({tag, "_tuser_src"}, DW'(m_tuser_src), DW'(0));
        chk({tag, "_hdr"}, DW'({hdr_valid, hdr_src, hdr_l3, hdr_l4, hdr_ports}), DW'(0));
    endtask

    task automatic model_reset();
        m_busy = 0; m_first = 0; pend = 0; m_owner = 0; m_ptr = 0;
        e_l3 = 0; e_l4 = 0; e_src = 0; e_ports = 0;
        for (int i = 0; i < NP; i++) begin
            q_src[i].delete();
            q_exp[i].delete();
        end
        s_tvalid = '0;
        s_tlast  = '0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < NP; i++) rand_valid[i] = 0;

        // reset with every port requesting
        s_tvalid = '1;
        m_rdy    = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        s_tvalid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // all four ports, two 3-beat packets each
        dut_log.delete();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) queue_pkt(p, rand512(), 3);
        run(200);
        chk("rr_order_size", DW'(dut_log.size()), DW'(8));
        for (int i = 0; i < 5; i++) chk("rr_order", DW'(dut_log[i]), DW'(i % NP));

        // port 2 IPv4/UDP 0x1234 -> 0x5678
        queue_pkt(2, mk_hdr(0, 17, 16'h1234, 16'h5678, 13'd0, 0, 0), 2);
        run(50);
        chk("v4udp_l3", DW'(hdr_l3), DW'(1));
        chk("v4udp_l4", DW'(hdr_l4), DW'(2));
        chk("v4udp_ports", DW'(hdr_ports), DW'(32'h12345678));
        chk("v4udp_src", DW'(hdr_src), DW'(2));

        // single-beat IPv6/TCP on port 1, then ports 0 and 2 race: pointer must favour 2
        queue_pkt(1, mk_hdr(1, 6, 16'hABCD, 16'h0050, 13'd0, 0, 0), 1);
        run(50);
        chk("v6tcp_l3", DW'(hdr_l3), DW'(2));
        chk("v6tcp_l4", DW'(hdr_l4), DW'(1));
        chk("v6tcp_src", DW'(hdr_src), DW'(1));
        dut_log.delete();
        queue_pkt(0, rand512(), 2);
        queue_pkt(2, rand512(), 2);
        run(50);
        chk("ptr_after_single_size", DW'(dut_log.size()), DW'(2));
        chk("ptr_after_single", DW'(dut_log[0]), DW'(2));

        // fragmented IPv4 and ARP
        queue_pkt(0, mk_hdr(0, 17, 16'h1111, 16'h2222, 13'h10, 0, 0), 2);
        run(50);
        chk("frag_l3", DW'(hdr_l3), DW'(1));
        chk("frag_l4", DW'(hdr_l4), DW'(0));
        chk("frag_ports", DW'(hdr_ports), DW'(0));
        queue_pkt(0, mk_hdr(2, 0, 16'h0, 16'h0, 13'd0, 0, 0), 1);
        run(50);
        chk("arp_l3", DW'(hdr_l3), DW'(0));
        chk("arp_l4", DW'(hdr_l4), DW'(0));
        chk("arp_ports", DW'(hdr_ports), DW'(0));

        // stalls and valid gaps on port 0 while port 3 waits
        rand_ready    = 1;
        rand_valid[0] = 1;
        dut_log.delete();
        queue_pkt(0, rand512(), 5);
        n = 0;
        while (!(m_busy && m_owner == 0) && n < 20) begin
            cycle();
            n++;
        end
        chk("port0_granted", DW'(n < 20), DW'(1));
        queue_pkt(3, rand512(), 3);
        run(300);
        chk("lock_order_size", DW'(dut_log.size()), DW'(2));
        chk("lock_first", DW'(dut_log[0]), DW'(0));
        chk("lock_second", DW'(dut_log[1]), DW'(3));

        // randomized traffic
        for (int i = 0; i < NP; i++) rand_valid[i] = 1;
        for (int i = 0; i < 40; i++) begin
            int kind, proto;
            kind  = $urandom % 4;
            case ($urandom % 4)
                0: proto = 6;
                1: proto = 17;
                2: proto = 1;
                default: proto = $urandom % 256;
            endcase
            queue_pkt($urandom % NP,
                      mk_hdr(kind, proto, 16'($urandom), 16'($urandom),
                             ($urandom % 4 == 0) ? 13'($urandom) : 13'd0,
                             ($urandom % 4 == 0), ($urandom % 5 == 0)),
                      1 + $urandom % 4);
        end
        run(5000);
        for (int i = 0; i < NP; i++) rand_valid[i] = 0;
        rand_ready = 0;

        // reset during beat 2 of a packet on port 1
        queue_pkt(1, rand512(), 4);
        n = 0;
        while (q_exp[1].size() > 3 && n < 20) begin
            cycle();
            n++;
        end
        chk("beat1_taken", DW'(q_exp[1].size()), DW'(3));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midpkt_reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dut_log.delete();
        queue_pkt(3, rand512(), 2);
        queue_pkt(0, rand512(), 2);
        run(50);
        chk("post_reset_size", DW'(dut_log.size()), DW'(2));
        chk("post_reset_first", DW'(dut_log[0]), DW'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
